// File: rtl/refill_arbiter.sv
// Shares the external memory port between I-Cache refills and D-Cache refills/write-backs.
// Optional macro REFILL_RR_EN selects round-robin tie-breaking; otherwise D-Cache wins ties.
module refill_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wnext,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy
);

    localparam int unsigned       CNT_W     = $clog2(LINE_WORDS);
    localparam int unsigned       OFF_W     = CNT_W + 2;
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RBURST,
        WBURST,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner_d;
    logic             pick_d;
`ifdef REFILL_RR_EN
    logic             last_d;
`endif

    // Arbitration decision for the IDLE cycle: 1 selects the D-Cache.
    always_comb begin
        pick_d = dc_req;
`ifdef REFILL_RR_EN
        if (dc_req && ic_req) begin
            pick_d = !last_d;
        end
`endif
    end

    // Burst sequencer; control outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            owner_d    <= 1'b0;
`ifdef REFILL_RR_EN
            last_d     <= 1'b0;
`endif
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wvalid <= 1'b0;
            ic_gnt     <= 1'b0;
            dc_gnt     <= 1'b0;
            ic_done    <= 1'b0;
            dc_done    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        owner_d  <= pick_d;
                        mem_we   <= pick_d && dc_we;
                        mem_addr <= (pick_d ? dc_addr : ic_addr) & ~LOW_MASK;
                        mem_req  <= 1'b1;
                        ic_gnt   <= !pick_d;
                        dc_gnt   <= pick_d;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            mem_wvalid <= 1'b1;
                            state      <= WBURST;
                        end else begin
                            state <= RBURST;
                        end
                    end
                end
                RBURST: begin
                    if (mem_rvalid) begin
                        if (cnt == LAST_BEAT) begin
                            ic_done <= !owner_d;
                            dc_done <= owner_d;
                            state   <= DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                WBURST: begin
                    if (mem_wready) begin
                        if (cnt == LAST_BEAT) begin
                            mem_wvalid <= 1'b0;
                            ic_done    <= !owner_d;
                            dc_done    <= owner_d;
                            state      <= DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    ic_gnt <= 1'b0;
                    dc_gnt <= 1'b0;
                    busy   <= 1'b0;
                    cnt    <= '0;
`ifdef REFILL_RR_EN
                    last_d <= owner_d;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat data paths pass straight through while the matching burst is active.
    assign rdata     = (state == RBURST) ? mem_rdata : '0;
    assign ic_rvalid = (state == RBURST) && !owner_d && mem_rvalid;
    assign dc_rvalid = (state == RBURST) && owner_d && mem_rvalid;
    assign mem_wdata = (state == WBURST) ? dc_wdata : '0;
    assign dc_wnext  = mem_wvalid && mem_wready;

endmodule

// File: tb/tb_refill_arbiter.sv
// Directed bench for refill_arbiter: table of single transfers plus arbitration and reset sequences.
module tb_refill_arbiter;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, dc_req, dc_we, mem_ack, mem_rvalid, mem_wready;
    logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
    logic        ic_gnt, ic_rvalid, ic_done, dc_wnext, dc_gnt, dc_rvalid, dc_done;
    logic        mem_req, mem_we, mem_wvalid, busy;
    logic [31:0] rdata, mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    refill_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_gnt     (ic_gnt),
        .ic_rvalid  (ic_rvalid),
        .ic_done    (ic_done),
        .dc_req     (dc_req),
        .dc_we      (dc_we),
        .dc_addr    (dc_addr),
        .dc_wdata   (dc_wdata),
        .dc_wnext   (dc_wnext),
        .dc_gnt     (dc_gnt),
        .dc_rvalid  (dc_rvalid),
        .dc_done    (dc_done),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_wdata  (mem_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          use_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] exp_addr;
        int          ack_dly;
        bit          toggle;
        bit          drop;
        logic [31:0] base;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ctrl"}, {mem_req, mem_we, mem_wvalid, ic_gnt, dc_gnt, ic_rvalid,
                             dc_rvalid, ic_done, dc_done, dc_wnext, busy}, 0);
    endtask

    // One complete transfer from IDLE; drives at posedge+1 and samples at negedge.
    task automatic xfer(input int idx, input vec_t v);
        int beats;
        int cyc;
        string t;
        t = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        if (v.use_d) begin
            dc_req = 1'b1; dc_we = v.we; dc_addr = v.addr;
        end else begin
            ic_req = 1'b1; ic_addr = v.addr; dc_we = 1'b0;
        end
        @(posedge clk); #1;
        chk({t, "_req"}, mem_req, 1);
        chk({t, "_addr"}, mem_addr, v.exp_addr);
        chk({t, "_we"}, mem_we, v.we);
        chk({t, "_gnt"}, {ic_gnt, dc_gnt}, v.use_d ? 2'b01 : 2'b10);
        chk({t, "_busy"}, busy, 1);
        for (int k = 0; k < v.ack_dly; k++) begin
            mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0000 + 32'(k);
            @(negedge clk);
            chk({t, "_req_hold"}, mem_req, 1);
            chk({t, "_stray"}, {ic_rvalid, dc_rvalid}, 0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b1; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < LW && cyc < 64) begin
            if (v.drop && beats == 2) begin
                ic_req = 1'b0; dc_req = 1'b0;
            end
            if (v.we) begin
                mem_wready = v.toggle ? (cyc % 2 == 0) : 1'b1;
                dc_wdata = v.base + 32'(beats);
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata = v.base + 32'(beats);
            end
            @(negedge clk);
            chk({t, "_mreq_low"}, mem_req, 0);
            chk({t, "_gnt_burst"}, {ic_gnt, dc_gnt}, v.use_d ? 2'b01 : 2'b10);
            chk({t, "_nodone"}, {ic_done, dc_done}, 0);
            if (v.we) begin
                chk({t, "_wvalid"}, mem_wvalid, 1);
                chk({t, "_wdata"}, mem_wdata, v.base + 32'(beats));
                chk({t, "_wnext"}, dc_wnext, mem_wready);
                if (mem_wready) beats++;
            end else begin
                chk({t, "_rvalid"}, {ic_rvalid, dc_rvalid}, v.use_d ? 2'b01 : 2'b10);
                chk({t, "_rdata"}, rdata, v.base + 32'(beats));
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_rvalid = 1'b0; mem_wready = 1'b0;
        chk({t, "_beats"}, beats, LW);
        chk({t, "_cycles"}, cyc, v.exp_cyc);
        @(negedge clk);
        chk({t, "_done"}, {ic_done, dc_done}, v.use_d ? 2'b01 : 2'b10);
        chk({t, "_gnt_done"}, {ic_gnt, dc_gnt}, v.use_d ? 2'b01 : 2'b10);
        chk({t, "_wvalid_done"}, {mem_wvalid, dc_wnext}, 0);
        ic_req = 1'b0; dc_req = 1'b0;
        @(posedge clk); #1;
        chk({t, "_idle"}, {ic_done, dc_done, ic_gnt, dc_gnt, busy, mem_req}, 0);
    endtask

    // Memory responder for one read transfer; drives and samples at negedge.
    task automatic serve_one(input string t, input bit keep_d, output bit who_d);
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({t, "_reqseen"}, mem_req, 1);
        chk({t, "_onegnt"}, ic_gnt ^ dc_gnt, 1);
        who_d = dc_gnt;
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        n = 0;
        while (!(ic_done || dc_done) && n < 40) begin
            @(negedge clk);
            mem_ack = 1'b0;
            n++;
        end
        mem_rvalid = 1'b0;
        chk({t, "_done"}, ic_done | dc_done, 1);
        if (ic_done) ic_req = 1'b0;
        if (dc_done && !keep_d) dc_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit who;
        bit exp_who[3];

        vecs[0] = '{use_d: 1'b0, we: 1'b0, addr: 32'h0000_1004, exp_addr: 32'h0000_1000,
                    ack_dly: 0, toggle: 1'b0, drop: 1'b0, base: 32'hA0, exp_cyc: LW};
        vecs[1] = '{use_d: 1'b1, we: 1'b1, addr: 32'h0000_2020, exp_addr: 32'h0000_2020,
                    ack_dly: 0, toggle: 1'b1, drop: 1'b0, base: 32'h100, exp_cyc: 2 * LW - 1};
        vecs[2] = '{use_d: 1'b1, we: 1'b0, addr: 32'h0000_303F, exp_addr: 32'h0000_3020,
                    ack_dly: 5, toggle: 1'b0, drop: 1'b0, base: 32'hB0, exp_cyc: LW};
        vecs[3] = '{use_d: 1'b0, we: 1'b0, addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFE0,
                    ack_dly: 1, toggle: 1'b0, drop: 1'b1, base: 32'hC0, exp_cyc: LW};
        vecs[4] = '{use_d: 1'b1, we: 1'b1, addr: 32'h0000_001C, exp_addr: 32'h0000_0000,
                    ack_dly: 0, toggle: 1'b0, drop: 1'b0, base: 32'h200, exp_cyc: LW};

        rst = 1'b0;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
        mem_wready = 1'b0; ic_addr = '0; dc_addr = '0; dc_wdata = 32'h1234; mem_rdata = 32'h77;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            xfer(i, vecs[i]);
        end

        // Simultaneous requests, each requester drops at its done.
        @(negedge clk);
        dc_req = 1'b1; ic_req = 1'b1; dc_addr = 32'h6000; ic_addr = 32'h7000; dc_we = 1'b0;
        serve_one("arb_a0", 1'b0, who); chk("arb_a0_owner", who, 1);
        serve_one("arb_a1", 1'b0, who); chk("arb_a1_owner", who, 0);
        dc_req = 1'b1; ic_req = 1'b1;
        serve_one("arb_b0", 1'b0, who); chk("arb_b0_owner", who, 1);
        serve_one("arb_b1", 1'b0, who); chk("arb_b1_owner", who, 0);

        // D-Cache re-requests immediately while I-Cache waits.
`ifdef REFILL_RR_EN
        exp_who[0] = 1'b1; exp_who[1] = 1'b0; exp_who[2] = 1'b1;
`else
        exp_who[0] = 1'b1; exp_who[1] = 1'b1; exp_who[2] = 1'b1;
`endif
        dc_req = 1'b1; ic_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve_one($sformatf("arb_c%0d", i), 1'b1, who);
            chk($sformatf("arb_c%0d_owner", i), who, exp_who[i]);
        end
        dc_req = 1'b0;
        if (ic_req) begin
            serve_one("arb_tail", 1'b0, who);
            chk("arb_tail_owner", who, 0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("arb_idle", busy, 0);

        // Reset during beat 3 of an I refill with a D request pending.
        ic_req = 1'b1; ic_addr = 32'h4444; dc_addr = 32'h5008; dc_we = 1'b0;
        begin
            int n;
            n = 0;
            while (!mem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rstmid_req", {mem_req, ic_gnt}, 2'b11);
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hE0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            chk("rstmid_beat", ic_rvalid, 1);
        end
        dc_req = 1'b1; ic_req = 1'b0;
        rst = 1'b0;
        #1;
        chk_all_zero("rstmid");
        mem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_dreq", {mem_req, dc_gnt, ic_gnt}, 3'b110);
        chk("rstmid_daddr", mem_addr, 32'h5000);
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hF0;
        for (int i = 0; i < LW; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            chk("rstmid_dbeat", {dc_rvalid, dc_done}, 2'b10);
        end
        @(negedge clk);
        chk("rstmid_ddone", {dc_done, dc_rvalid}, 2'b10);
        mem_rvalid = 1'b0; dc_req = 1'b0;
        @(negedge clk);
        chk("rstmid_idle", {busy, dc_done, dc_gnt}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/refill_arbiter.md
Name: refill_arbiter

Overview:
- Arbitrates the single external memory port between I-Cache refills (IF stage) and D-Cache refills/write-backs (MEM stage).
- Sequences each line transfer as a multi-beat burst.
- Returns per-requester grant, data and done handshakes.
- The i_ICache_Miss / i_DCache_Miss stall inputs of the hazard logic are held until the matching done pulse.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, beat data width
- LINE_WORDS, 8, beats per line; power of two, minimum 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- ic_req  in  1  I-Cache refill request; held high until ic_done
- ic_addr  in  ADDR_W  I-Cache miss address; stable while ic_req high
- ic_gnt  out  1  I-Cache owns the port
- ic_rvalid  out  1  refill beat valid for I-Cache
- ic_done  out  1  one-cycle end-of-transfer pulse to I-Cache
- dc_req  in  1  D-Cache request; held high until dc_done
- dc_we  in  1  1 = line write-back, 0 = refill; stable while dc_req high
- dc_addr  in  ADDR_W  D-Cache line address
- dc_wdata  in  DATA_W  current write-back beat
- dc_wnext  out  1  write beat consumed; D-Cache advances to the next word
- dc_gnt  out  1  D-Cache owns the port
- dc_rvalid  out  1  refill beat valid for D-Cache
- dc_done  out  1  one-cycle end-of-transfer pulse to D-Cache
- rdata  out  DATA_W  refill beat data, shared by both caches; qualify with *_rvalid
- mem_req  out  1  burst request to memory
- mem_we  out  1  burst direction
- mem_addr  out  ADDR_W  line-aligned burst address
- mem_ack  in  1  memory accepts the request
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  DATA_W  read beat data
- mem_wvalid  out  1  write beat valid
- mem_wready  in  1  memory accepts write beat
- mem_wdata  out  DATA_W  write beat data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst low, asynchronous): FSM enters IDLE; beat counter = 0; owner = I; last-served = I.
- Reset values: every output = 0.
- A reset asserted mid-burst abandons the transfer. mem_req, mem_wvalid, gnt and done drop immediately; no done pulse is issued.
- FSM states: IDLE, REQ, RBURST, WBURST, DONE.
- IDLE: on a clock edge where any request is high, latch the owner, mem_we (dc_we, or 0 for I-Cache) and the aligned address, then go to REQ.
  - Aligned address = request address with the low log2(LINE_WORDS)+2 bits forced to 0.
  - Both requests high in the same cycle: D-Cache wins.
- REQ: mem_req = 1; the owner's gnt = 1.
  - Stay in REQ until mem_ack.
  - On mem_ack, go to RBURST (mem_we = 0) or WBURST (mem_we = 1).
  - mem_rvalid seen in REQ is ignored.
- RBURST:
  - rdata = mem_rdata (combinational).
  - owner's rvalid = mem_rvalid (combinational).
  - Counter increments on each mem_rvalid.
  - On the beat where counter == LINE_WORDS-1, go to DONE.
- WBURST:
  - mem_wvalid = 1.
  - mem_wdata = dc_wdata (combinational).
  - dc_wnext = mem_wvalid & mem_wready.
  - Counter increments on each handshake.
  - On the last handshake, go to DONE.
- DONE: owner's done = 1 for exactly one cycle; gnt is still high; update last-served; clear the counter; go to IDLE.
- gnt is high from the cycle after the IDLE decision through DONE inclusive. Exactly one gnt is high at a time.
- Minimum gap: one IDLE cycle between DONE and the next REQ.
- Latency, request edge N:
  - mem_req is high in cycle N+1.
  - With mem_ack in N+1 and one beat per cycle, done is in cycle N+2+LINE_WORDS.
- A requester dropping req mid-transfer has no effect: the burst completes and done still pulses.
- Inputs to a non-owner are ignored.
- Counter width = log2(LINE_WORDS). It wraps to 0 only through DONE.

Optional Feature:
- Macro: REFILL_RR_EN
- Defined: round-robin arbitration. On simultaneous requests in IDLE, the requester not in last-served wins. After reset, last-served = I, so D wins the first tie.
- Undefined: fixed priority, D-Cache always wins ties. The last-served register is omitted.

Test Plan:
- Single I refill: ic_req with ic_addr=0x1004, mem_ack at first mem_req cycle, 8 consecutive mem_rvalid (0xA0..0xA7) -> mem_addr=0x1000, mem_we=0, ic_rvalid ×8 with rdata 0xA0..0xA7, ic_done one cycle, dc_gnt never high.
- D write-back with backpressure: dc_we=1, dc_addr=0x2020, mem_wready toggling 1,0,1,… -> exactly 8 dc_wnext pulses, mem_wdata tracks dc_wdata, dc_done after 8th handshake.
- Simultaneous requests, same cycle: macro off -> D served then I, twice in a row. Macro on -> D, then I, then D on re-request.
- mem_ack delayed 5 cycles, mem_rvalid pulsed during REQ -> mem_req held 5 cycles, stray beat not forwarded, beat count unaffected.
- rst low at beat 3 of a refill -> all outputs 0 asynchronously. After release, a pending dc_req starts a fresh REQ with counter 0.
- ic_req dropped at beat 2 -> burst still completes 8 beats, ic_done pulses, FSM returns to IDLE.
